// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-port AXI4-Lite arbiter.
// Holds the transaction FSM states, the port index type and the response codes.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef logic [0:0] port_idx_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] idx_to_onehot(input port_idx_t idx);
    return (idx == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_rr.sv
// Two-request round-robin arbiter with a one-hot combinational grant.
// The priority pointer moves to the losing port only when the owner's transaction retires.
module rr_arbiter2
  import axi_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic [1:0] req_i,
  input  logic      update_i,
  input  port_idx_t winner_i,
  output logic [1:0] gnt_o
);

  port_idx_t rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (update_i) begin
      rr_ptr_d = ~winner_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = idx_to_onehot(rr_ptr_q);
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one downstream AXI4-Lite slave between two upstream masters, one whole
// transaction at a time; all channels are forwarded combinationally from the owner.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int DATA_WIDTH    = 32,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // upstream ports, index 0 = s0, index 1 = s1
  input  logic [1:0]                    s_awvalid_i,
  output logic [1:0]                    s_awready_o,
  input  logic [1:0][ADDRESS_WIDTH-1:0] s_awaddr_i,
  input  logic [1:0]                    s_wvalid_i,
  output logic [1:0]                    s_wready_o,
  input  logic [1:0][DATA_WIDTH-1:0]    s_wdata_i,
  input  logic [1:0][STRB_WIDTH-1:0]    s_wstrb_i,
  output logic [1:0]                    s_bvalid_o,
  input  logic [1:0]                    s_bready_i,
  output logic [1:0][1:0]               s_bresp_o,
  input  logic [1:0]                    s_arvalid_i,
  output logic [1:0]                    s_arready_o,
  input  logic [1:0][ADDRESS_WIDTH-1:0] s_araddr_i,
  output logic [1:0]                    s_rvalid_o,
  input  logic [1:0]                    s_rready_i,
  output logic [1:0][DATA_WIDTH-1:0]    s_rdata_o,
  output logic [1:0][1:0]               s_rresp_o,
  // downstream port towards the bridge
  output logic                          m_awvalid_o,
  input  logic                          m_awready_i,
  output logic [ADDRESS_WIDTH-1:0]      m_awaddr_o,
  output logic                          m_wvalid_o,
  input  logic                          m_wready_i,
  output logic [DATA_WIDTH-1:0]         m_wdata_o,
  output logic [STRB_WIDTH-1:0]         m_wstrb_o,
  input  logic                          m_bvalid_i,
  output logic                          m_bready_o,
  input  logic [1:0]                    m_bresp_i,
  output logic                          m_arvalid_o,
  input  logic                          m_arready_i,
  output logic [ADDRESS_WIDTH-1:0]      m_araddr_o,
  input  logic                          m_rvalid_i,
  output logic                          m_rready_o,
  input  logic [DATA_WIDTH-1:0]         m_rdata_i,
  input  logic [1:0]                    m_rresp_i,
  output logic [1:0]                    grant_o,
  output logic                          busy_o
);

  arb_state_e state_q, state_d;
  port_idx_t  owner_q, owner_d;
  logic       write_q, write_d;
  logic [1:0] req;
  logic [1:0] arb_gnt;
  logic       rr_update;

  assign req = s_awvalid_i | s_arvalid_i;

  rr_arbiter2 u_rr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .update_i (rr_update),
    .winner_i (owner_q),
    .gnt_o    (arb_gnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
    end
  end

  // Only the channel belonging to the current phase is connected; everything else is parked at zero.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    rr_update   = 1'b0;
    s_awready_o = '0;
    s_wready_o  = '0;
    s_bvalid_o  = '0;
    s_bresp_o   = '0;
    s_arready_o = '0;
    s_rvalid_o  = '0;
    s_rdata_o   = '0;
    s_rresp_o   = '0;
    m_awvalid_o = 1'b0;
    m_awaddr_o  = '0;
    m_wvalid_o  = 1'b0;
    m_wdata_o   = '0;
    m_wstrb_o   = '0;
    m_bready_o  = 1'b0;
    m_arvalid_o = 1'b0;
    m_araddr_o  = '0;
    m_rready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          owner_d = (arb_gnt == 2'b10) ? 1'b1 : 1'b0;
          write_d = s_awvalid_i[owner_d];
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (write_q) begin
          m_awvalid_o          = s_awvalid_i[owner_q];
          m_awaddr_o           = s_awaddr_i[owner_q];
          s_awready_o[owner_q] = m_awready_i;
          if (m_awvalid_o && m_awready_i) begin
            state_d = WDATA;
          end
        end else begin
          m_arvalid_o          = s_arvalid_i[owner_q];
          m_araddr_o           = s_araddr_i[owner_q];
          s_arready_o[owner_q] = m_arready_i;
          if (m_arvalid_o && m_arready_i) begin
            state_d = RESP;
          end
        end
      end
      WDATA: begin
        m_wvalid_o          = s_wvalid_i[owner_q];
        m_wdata_o           = s_wdata_i[owner_q];
        m_wstrb_o           = s_wstrb_i[owner_q];
        s_wready_o[owner_q] = m_wready_i;
        if (m_wvalid_o && m_wready_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (write_q) begin
          s_bvalid_o[owner_q] = m_bvalid_i;
          s_bresp_o[owner_q]  = m_bresp_i;
          m_bready_o          = s_bready_i[owner_q];
          if (m_bvalid_i && m_bready_o) begin
            state_d   = IDLE;
            rr_update = 1'b1;
          end
        end else begin
          s_rvalid_o[owner_q] = m_rvalid_i;
          s_rdata_o[owner_q]  = m_rdata_i;
          s_rresp_o[owner_q]  = m_rresp_i;
          m_rready_o          = s_rready_i[owner_q];
          if (m_rvalid_i && m_rready_o) begin
            state_d   = IDLE;
            rr_update = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o = (state_q == IDLE) ? 2'b00 : idx_to_onehot(owner_q);
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: two upstream master agents, a small bridge model,
// and a transaction-level reference that predicts every output on every cycle.
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;

  logic             clk;
  logic             rst_ni;
  logic [1:0]       s_awvalid_i, s_awready_o, s_wvalid_i, s_wready_o;
  logic [1:0]       s_bvalid_o, s_bready_i, s_arvalid_i, s_arready_o;
  logic [1:0]       s_rvalid_o, s_rready_i;
  logic [1:0][31:0] s_awaddr_i, s_wdata_i, s_araddr_i, s_rdata_o;
  logic [1:0][3:0]  s_wstrb_i;
  logic [1:0][1:0]  s_bresp_o, s_rresp_o;
  logic             m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
  logic             m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic             m_rvalid_i, m_rready_o;
  logic [31:0]      m_awaddr_o, m_wdata_o, m_araddr_o, m_rdata_i;
  logic [3:0]       m_wstrb_o;
  logic [1:0]       m_bresp_i, m_rresp_i, grant_o;
  logic             busy_o;

  int total = 0;
  int bad = 0;

  // bridge model configuration and capture
  logic        bridgeErr = 1'b0;
  logic [31:0] bridgeRdata = '0;
  logic [31:0] lastAwAddr = '0, lastWData = '0, lastArAddr = '0;
  logic [3:0]  lastWStrb = '0;
  logic [1:0]  grantLog[$];

  // reference-model expectations
  logic             eAwv, eWv, eBr, eArv, eRr, eBusy;
  logic [31:0]      eAwa, eWd, eAra;
  logic [3:0]       eWs;
  logic [1:0]       eGrant;
  logic [1:0]       eSAwr, eSWr, eSBv, eSArr, eSRv;
  logic [1:0][1:0]  eSBresp, eSRresp;
  logic [1:0][31:0] eSRd;

  axi_lite_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake edge.
  task automatic waitHs(input int p, input int ch, output logic [31:0] dataCap, output logic [1:0] respCap);
    bit seen;
    seen = 1'b0;
    dataCap = '0;
    respCap = '0;
    for (int n = 0; n < 100 && !seen; n++) begin
      #4;
      case (ch)
        0:       seen = s_awready_o[p];
        1:       seen = s_wready_o[p];
        2:       seen = s_bvalid_o[p];
        3:       seen = s_arready_o[p];
        default: seen = s_rvalid_o[p];
      endcase
      if (seen) begin
        dataCap = s_rdata_o[p];
        respCap = (ch == 2) ? s_bresp_o[p] : s_rresp_o[p];
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake timeout port=%0d chan=%0d: got none expected handshake", p, ch);
    end
  endtask

  // W is presented together with AW so the early-W hold-off is exercised every time.
  task automatic writeTxn(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    s_awvalid_i[p] = 1'b1; s_awaddr_i[p] = addr;
    s_wvalid_i[p] = 1'b1; s_wdata_i[p] = data; s_wstrb_i[p] = strb;
    waitHs(p, 0, d, r);
    s_awvalid_i[p] = 1'b0; s_awaddr_i[p] = '0;
    waitHs(p, 1, d, r);
    s_wvalid_i[p] = 1'b0; s_wdata_i[p] = '0; s_wstrb_i[p] = '0;
    s_bready_i[p] = 1'b1;
    waitHs(p, 2, d, resp);
    s_bready_i[p] = 1'b0;
  endtask

  task automatic readTxn(input int p, input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    s_arvalid_i[p] = 1'b1; s_araddr_i[p] = addr;
    waitHs(p, 3, d, r);
    s_arvalid_i[p] = 1'b0; s_araddr_i[p] = '0;
    s_rready_i[p] = 1'b1;
    waitHs(p, 4, data, resp);
    s_rready_i[p] = 1'b0;
  endtask

  // Bridge: always-ready address/data channels, response two cycles after the request completes.
  initial begin : bridgeModel
    int  bDelay, rDelay;
    bit  dropB, dropR;
    bDelay = -1; rDelay = -1; dropB = 1'b0; dropR = 1'b0;
    m_awready_i = 1'b1; m_wready_i = 1'b1; m_arready_i = 1'b1;
    m_bvalid_i = 1'b0; m_bresp_i = '0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        m_bvalid_i = 1'b0; m_bresp_i = '0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0;
        bDelay = -1; rDelay = -1; dropB = 1'b0; dropR = 1'b0;
      end else begin
        if (dropB) begin m_bvalid_i = 1'b0; m_bresp_i = '0; dropB = 1'b0; end
        if (dropR) begin m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; dropR = 1'b0; end
        if (bDelay == 0) begin
          m_bvalid_i = 1'b1; m_bresp_i = bridgeErr ? RESP_SLVERR : RESP_OKAY; bDelay = -1;
        end else if (bDelay > 0) bDelay--;
        if (rDelay == 0) begin
          m_rvalid_i = 1'b1; m_rdata_i = bridgeRdata;
          m_rresp_i = bridgeErr ? RESP_SLVERR : RESP_OKAY; rDelay = -1;
        end else if (rDelay > 0) rDelay--;
        #4;
        if (rst_ni) begin
          if (m_awvalid_o && m_awready_i) lastAwAddr = m_awaddr_o;
          if (m_wvalid_o && m_wready_i) begin lastWData = m_wdata_o; lastWStrb = m_wstrb_o; bDelay = 2; end
          if (m_arvalid_o && m_arready_i) begin lastArAddr = m_araddr_o; rDelay = 2; end
          if (m_bvalid_i && m_bready_o) dropB = 1'b1;
          if (m_rvalid_i && m_rready_o) dropR = 1'b1;
        end
      end
    end
  end

  // Reference: an owner plus a position in its channel list (AW,W,B or AR,R); outputs follow from that.
  initial begin : compareModel
    int         mOwner, mStep, mPtr;
    bit         mWrite, fire;
    logic       r0, r1;
    logic [1:0] prevGrant;
    mOwner = -1; mStep = 0; mPtr = 0; mWrite = 1'b0; prevGrant = 2'b00;
    forever begin
      @(negedge clk);
      #4;
      eAwv = 0; eAwa = '0; eWv = 0; eWd = '0; eWs = '0; eBr = 0; eArv = 0; eAra = '0; eRr = 0;
      eSAwr = '0; eSWr = '0; eSBv = '0; eSBresp = '0; eSArr = '0; eSRv = '0; eSRd = '0; eSRresp = '0;
      eGrant = 2'b00; eBusy = 1'b0;
      if (!rst_ni) begin
        mOwner = -1; mPtr = 0;
      end else if (mOwner >= 0) begin
        eGrant = (mOwner == 0) ? 2'b01 : 2'b10;
        eBusy = 1'b1;
        if (mWrite && mStep == 0) begin
          eAwv = s_awvalid_i[mOwner]; eAwa = s_awaddr_i[mOwner]; eSAwr[mOwner] = m_awready_i;
        end else if (mWrite && mStep == 1) begin
          eWv = s_wvalid_i[mOwner]; eWd = s_wdata_i[mOwner]; eWs = s_wstrb_i[mOwner];
          eSWr[mOwner] = m_wready_i;
        end else if (mWrite) begin
          eSBv[mOwner] = m_bvalid_i; eSBresp[mOwner] = m_bresp_i; eBr = s_bready_i[mOwner];
        end else if (mStep == 0) begin
          eArv = s_arvalid_i[mOwner]; eAra = s_araddr_i[mOwner]; eSArr[mOwner] = m_arready_i;
        end else begin
          eSRv[mOwner] = m_rvalid_i; eSRd[mOwner] = m_rdata_i; eSRresp[mOwner] = m_rresp_i;
          eRr = s_rready_i[mOwner];
        end
      end
      checkOutput("grant/busy", {grant_o, busy_o}, {eGrant, eBusy});
      checkOutput("m side", {m_awvalid_o, m_awaddr_o, m_wvalid_o, m_wdata_o, m_wstrb_o, m_bready_o,
                             m_arvalid_o, m_araddr_o, m_rready_o},
                            {eAwv, eAwa, eWv, eWd, eWs, eBr, eArv, eAra, eRr});
      checkOutput("s side", {s_awready_o, s_wready_o, s_bvalid_o, s_bresp_o, s_arready_o, s_rvalid_o,
                             s_rdata_o, s_rresp_o},
                            {eSAwr, eSWr, eSBv, eSBresp, eSArr, eSRv, eSRd, eSRresp});
      if (rst_ni && grant_o != 2'b00 && prevGrant == 2'b00) grantLog.push_back(grant_o);
      prevGrant = grant_o;
      if (rst_ni) begin
        if (mOwner < 0) begin
          r0 = s_awvalid_i[0] | s_arvalid_i[0];
          r1 = s_awvalid_i[1] | s_arvalid_i[1];
          if (r0 || r1) begin
            mOwner = (r0 && r1) ? mPtr : (r0 ? 0 : 1);
            mWrite = s_awvalid_i[mOwner];
            mStep = 0;
          end
        end else begin
          if (mWrite)
            fire = (mStep == 0) ? (eAwv && m_awready_i) : (mStep == 1) ? (eWv && m_wready_i) : (m_bvalid_i && eBr);
          else
            fire = (mStep == 0) ? (eArv && m_arready_i) : (m_rvalid_i && eRr);
          if (fire) begin
            mStep++;
            if (mStep == (mWrite ? 3 : 2)) begin
              mPtr = 1 - mOwner;
              mOwner = -1;
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus();
    logic [1:0]  resp0, resp1, rresp0;
    logic [31:0] rd0;
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  expLog[12];

    // single write on s0
    writeTxn(0, 32'h10, 32'hDEAD_BEEF, 4'hF, resp0);
    checkOutput("s0 write bresp", resp0, RESP_OKAY);
    checkOutput("bridge awaddr", lastAwAddr, 32'h10);
    checkOutput("bridge wdata", lastWData, 32'hDEAD_BEEF);
    checkOutput("bridge wstrb", lastWStrb, 4'hF);

    // single read on s1
    bridgeRdata = 32'h1234_5678;
    readTxn(1, 32'h24, rd0, rresp0);
    checkOutput("s1 read rdata", rd0, 32'h1234_5678);
    checkOutput("s1 read rresp", rresp0, RESP_OKAY);
    checkOutput("bridge araddr", lastArAddr, 32'h24);

    // simultaneous writes, twice
    for (int rep = 0; rep < 2; rep++) begin
      fork
        writeTxn(0, 32'h100, 32'h1111_0100, 4'hF, resp0);
        writeTxn(1, 32'h104, 32'h2222_0104, 4'h3, resp1);
      join
      checkOutput("dual s0 bresp", resp0, RESP_OKAY);
      checkOutput("dual s1 bresp", resp1, RESP_OKAY);
      checkOutput("dual last awaddr", lastAwAddr, 32'h104);
    end

    // write and read together on s0
    bridgeRdata = 32'hA5A5_0204;
    fork
      writeTxn(0, 32'h200, 32'h0000_0200, 4'h1, resp0);
      readTxn(0, 32'h204, rd0, rresp0);
    join
    checkOutput("s0 w+r bresp", resp0, RESP_OKAY);
    checkOutput("s0 w+r rdata", rd0, 32'hA5A5_0204);
    checkOutput("s0 w+r rresp", rresp0, RESP_OKAY);

    // slave error on s1 read, then a clean s0 write
    bridgeErr = 1'b1;
    readTxn(1, 32'h300, rd0, rresp0);
    bridgeErr = 1'b0;
    checkOutput("s1 slverr rresp", rresp0, 2'b10);
    writeTxn(0, 32'h304, 32'h0000_0304, 4'hF, resp0);
    checkOutput("s0 after err bresp", resp0, 2'b00);

    // reset while an s0 write waits for its data beat
    @(negedge clk);
    s_awvalid_i[0] = 1'b1; s_awaddr_i[0] = 32'h400;
    waitHs(0, 0, d, r);
    s_awvalid_i[0] = 1'b0; s_awaddr_i[0] = '0;
    #1;
    checkOutput("wdata busy", busy_o, 1'b1);
    checkOutput("wdata grant", grant_o, 2'b01);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid reset grant", grant_o, 2'b00);
    checkOutput("mid reset busy", busy_o, 1'b0);
    checkOutput("mid reset m", {m_awvalid_o, m_awaddr_o, m_wvalid_o, m_wdata_o, m_wstrb_o, m_bready_o,
                                m_arvalid_o, m_araddr_o, m_rready_o}, '0);
    checkOutput("mid reset s", {s_awready_o, s_wready_o, s_bvalid_o, s_bresp_o, s_arready_o, s_rvalid_o,
                                s_rdata_o, s_rresp_o}, '0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    bridgeRdata = 32'hCAFE_F00D;
    readTxn(1, 32'h500, rd0, rresp0);
    checkOutput("post reset rdata", rd0, 32'hCAFE_F00D);
    checkOutput("post reset rresp", rresp0, RESP_OKAY);
    checkOutput("post reset araddr", lastArAddr, 32'h500);
    repeat (2) @(negedge clk);

    expLog = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    checkOutput("grant count", grantLog.size(), 12);
    for (int i = 0; i < 12 && i < grantLog.size(); i++) begin
      checkOutput($sformatf("grant order %0d", i), grantLog[i], expLog[i]);
    end
  endtask

  initial begin : mainSeq
    s_awvalid_i = '0; s_awaddr_i = '0; s_wvalid_i = '0; s_wdata_i = '0; s_wstrb_i = '0;
    s_bready_i = '0; s_arvalid_i = '0; s_araddr_i = '0; s_rready_i = '0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #6;
    checkOutput("reset grant", grant_o, 2'b00);
    checkOutput("reset busy", busy_o, 1'b0);
    checkOutput("reset m", {m_awvalid_o, m_awaddr_o, m_wvalid_o, m_wdata_o, m_wstrb_o, m_bready_o,
                            m_arvalid_o, m_araddr_o, m_rready_o}, '0);
    checkOutput("reset s", {s_awready_o, s_wready_o, s_bvalid_o, s_bresp_o, s_arready_o, s_rvalid_o,
                            s_rdata_o, s_rresp_o}, '0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
